cla_add_sequencer: RTL and testbench
====================================

# cla_add_sequencer

Multi-cycle N-bit adder controller that reuses one 4-bit carry-lookahead slice, one nibble per clock, least significant nibble first. The inter-nibble carry is held in a flip-flop between cycles. The block sits between a requester and a consumer, with a valid/ready handshake on each side. It lets the 4-bit CLA datapath serve wide additions without instantiating WIDTH/4 slices.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of 4 and at least 4.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  requester presents a, b, cin.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  addend A; sampled on accept.
- b  input  WIDTH  addend B; sampled on accept.
- cin  input  1  carry-in; sampled on accept.
- out_valid  output  1  sum, cout and ovf are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow.

## Operation
- NSLICE = WIDTH/4. The nibble counter is $clog2(NSLICE) bits wide, minimum 1.
- Registers:
  - a_sh, b_sh: operand shift registers.
  - sum_sh: result shift register.
  - carry_q: carry flop.
  - a_msb, b_msb: MSBs captured on accept.
  - cnt: nibble counter.
  - state.
- FSM states and transitions:
  - IDLE:
    - in_ready=1.
    - On in_valid: load a_sh=a, b_sh=b, carry_q=cin, cnt=0.
    - Capture a_msb=a[WIDTH-1], b_msb=b[WIDTH-1].
    - Go to RUN.
  - RUN, one nibble per cycle:
    - Slice inputs are a_sh[3:0], b_sh[3:0] and carry_q.
    - sum_sh shifts right by 4, with the slice sum entering at [WIDTH-1:WIDTH-4].
    - a_sh and b_sh shift right by 4, zero-filled.
    - carry_q takes the slice carry-out.
    - cnt increments.
    - When cnt==NSLICE-1, go to DONE.
  - DONE:
    - out_valid=1.
    - sum=sum_sh, cout=carry_q.
    - ovf = (a_msb==b_msb) && (sum_sh[WIDTH-1]!=a_msb).
    - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. The requester holds its data until in_ready.
- Outputs are held stable throughout DONE, however long out_ready stays low.
- Outputs outside DONE:
  - sum, cout and ovf show the internal registers.
  - Their values are don't-care; consumers qualify them with out_valid.
  - Benches check them only when out_valid=1.
- No arithmetic is widened beyond WIDTH. The only overflow outputs are cout and ovf.

## Timing
- Reset values while rst is high, applied asynchronously:
  - state=IDLE, so in_ready=1 and out_valid=0.
  - sum_sh, a_sh, b_sh=0.
  - carry_q, cnt, a_msb, b_msb=0, so sum=0, cout=0 and ovf=0.
- Reset mid-operation (RUN or DONE) aborts the operation without producing a result. The first rising edge after deassertion can accept a new operation.
- Latency: with accept at edge k, out_valid rises after edge k+NSLICE. For WIDTH=16 this is 4 edges.
- Minimum period per operation is NSLICE+2 edges: accept, NSLICE RUN edges, then the output handshake edge. in_ready returns the cycle after the output handshake.
- WIDTH=4 gives a single RUN cycle, with cnt 1 bit wide and its terminal value 0.
- The carry chain within a cycle is combinational through the slice only. carry_q is the sole path between nibbles.

## Structure
- Shared package cla_pkg holds:
  - SLICE_W=4.
  - An FSM state enum: IDLE, RUN, DONE.
  - A function nslice(width) returning width/SLICE_W.
- Sub-module cla4_slice, purely combinational:
  - Inputs a[3:0], b[3:0], ci.
  - Outputs s[3:0], co.
  - Generate/propagate lookahead: g=a&b, p=a^b, c(i+1)=g(i)|p(i)&c(i), expanded two-level.
- Elaboration check: the sequencer fails if WIDTH%4 != 0 or WIDTH < 4.

## Test plan
1. WIDTH=16, a=0xFFFF, b=0x0001, cin=0 → after 4 edges, out_valid=1, sum=0x0000, cout=1, ovf=0.
2. a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
3. a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, ovf=0. Separately, a=0x0FFF, b=0x0001 → sum=0x1000, checking carry propagation across all nibble boundaries.
4. Backpressure:
   - Hold out_ready=0 for 5 cycles in DONE → out_valid, sum, cout and ovf stay constant and in_ready stays 0.
   - Raise out_ready → in_ready=1 the next cycle.
   - Toggling in_valid with new operands during RUN does not change the result.
5. Assert rst during RUN with cnt=2 → out_valid=0, in_ready=1 and sum=0 immediately, without waiting for a clock edge. A following op 0x0002+0x0003 gives sum=0x0005 with no residue from the aborted operation.
6. Back-to-back and other widths:
   - 100 random operations with random in_valid/out_ready gaps → every result equals (a+b+cin) mod 2^16. Each accept-to-out_valid gap is 4 edges; back-to-back spacing is at least 6 edges.
   - Repeat at WIDTH=4 (latency 1) and WIDTH=32 (latency 8).

Source files
------------

// File: rtl/cla_add_sequencer_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder sequencer.
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_add_sequencer_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice, carries expanded two-level.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Every carry is a flat sum of products of g, p and ci: no ripple through c_s.
    assign c_s[0] = ci;
    assign c_s[1] = g_s[0] | (p_s[0] & ci);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & ci);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);

    assign s  = p_s ^ c_s[3:0];
    assign co = c_s[4];

endmodule

// File: rtl/cla_add_sequencer.sv
// WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble per clock, LSB nibble first,
// with valid/ready handshakes on the operand and result sides.
module cla_add_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("cla_add_sequencer: WIDTH must be a positive multiple of 4");
    end

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,      b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q,    sum_sh_d;
    logic               carry_q,     carry_d;
    logic               a_msb_q,     a_msb_d;
    logic               b_msb_q,     b_msb_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               ovf_q,       ovf_d;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;

    cla4_slice u_slice (
        .a  (a_sh_q[SLICE_W-1:0]),
        .b  (b_sh_q[SLICE_W-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // Next-state and datapath update; handshake flags and ovf are registered with the state.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        carry_d     = carry_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    carry_d    = cin;
                    a_msb_d    = a[WIDTH-1];
                    b_msb_d    = b[WIDTH-1];
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_sh_d = (sum_sh_q >> SLICE_W) | (WIDTH'(slice_s) << (WIDTH - SLICE_W));
                a_sh_d   = a_sh_q >> SLICE_W;
                b_sh_d   = b_sh_q >> SLICE_W;
                carry_d  = slice_co;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // The final slice produces the sum MSB, so overflow is known on this edge.
                    ovf_d       = (a_msb_q == b_msb_q) && (slice_s[SLICE_W-1] != a_msb_q);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            carry_q     <= carry_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_sh_q;
    assign cout      = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Self-checking bench: directed and random additions on WIDTH=4, 16 and 32 instances
// against an integer-arithmetic reference model.
module tb_cla_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_bus, b_bus;
    logic        cin;
    logic [2:0]  in_valid, out_ready, in_ready, out_valid, cout, ovf;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic [31:0] sum32;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cla_add_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_bus[3:0]), .b(b_bus[3:0]), .cin(cin), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum4), .cout(cout[0]), .ovf(ovf[0]));

    cla_add_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_bus[15:0]), .b(b_bus[15:0]), .cin(cin), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum16), .cout(cout[1]), .ovf(ovf[1]));

    cla_add_sequencer #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_bus), .b(b_bus), .cin(cin), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .sum(sum32), .cout(cout[2]), .ovf(ovf[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sum_of(input int k);
        case (k)
            0:       return {28'd0, sum4};
            1:       return {16'd0, sum16};
            default: return sum32;
        endcase
    endfunction

    // One full operation on instance k (0:W4, 1:W16, 2:W32) with reference-model checks.
    task automatic op(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                      input int hold, input bit toggle, input int exp_spacing);
        int w, n, acc;
        logic [31:0] mask, exp_sum;
        logic [63:0] full;
        logic exp_cout, exp_ovf;
        longint sa, sb, ssum, lim;
        w    = (k == 0) ? 4 : ((k == 1) ? 16 : 32);
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {32'd0, a & mask} + {32'd0, b & mask} + {63'd0, c};
        exp_sum  = full[31:0] & mask;
        exp_cout = full[w];
        lim  = 64'sd1 <<< (w - 1);
        sa   = longint'({32'd0, a & mask});
        sb   = longint'({32'd0, b & mask});
        if (a[w-1]) sa = sa - (lim * 2);
        if (b[w-1]) sb = sb - (lim * 2);
        ssum = sa + sb + longint'(c);
        exp_ovf = (ssum >= lim) || (ssum < -lim);

        chk("in_ready_idle", {63'd0, in_ready[k]}, 64'd1);
        a_bus = a; b_bus = b; cin = c;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        if (exp_spacing > 0) chk("spacing", 64'(acc - last_acc), 64'(exp_spacing));
        last_acc = acc;
        in_valid[k] = 1'b0;
        n = 0;
        while (!out_valid[k] && n < 40) begin
            if (toggle) begin
                in_valid[k] = $urandom_range(1, 0) == 1;
                a_bus = $urandom; b_bus = $urandom; cin = $urandom_range(1, 0) == 1;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid[k] = 1'b0;
        chk("latency", 64'(n), 64'(w / 4));
        chk("out_valid", {63'd0, out_valid[k]}, 64'd1);
        chk("sum", {32'd0, sum_of(k)}, {32'd0, exp_sum});
        chk("cout", {63'd0, cout[k]}, {63'd0, exp_cout});
        chk("ovf", {63'd0, ovf[k]}, {63'd0, exp_ovf});
        chk("in_ready_done", {63'd0, in_ready[k]}, 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, out_valid[k]}, 64'd1);
            chk("hold_sum", {32'd0, sum_of(k)}, {32'd0, exp_sum});
            chk("hold_flags", {62'd0, cout[k], ovf[k]}, {62'd0, exp_cout, exp_ovf});
            chk("hold_ready", {63'd0, in_ready[k]}, 64'd0);
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk("release_valid", {63'd0, out_valid[k]}, 64'd0);
        chk("release_ready", {63'd0, in_ready[k]}, 64'd1);
    endtask

    initial begin
        int gap, hold, prev_hold;
        rst = 1'b1;
        in_valid = 3'b000; out_ready = 3'b000;
        a_bus = 32'd0; b_bus = 32'd0; cin = 1'b0;
        #1;
        chk("rst_in_ready", {61'd0, in_ready}, 64'd7);
        chk("rst_out_valid", {61'd0, out_valid}, 64'd0);
        chk("rst_sum16", {48'd0, sum16}, 64'd0);
        chk("rst_flags", {58'd0, cout, ovf}, 64'd0);
        #12 rst = 1'b0;
        @(posedge clk); #1;

        op(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, 0);
        op(1, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 0, 1'b0, 0);
        op(1, 32'h0000_8000, 32'h0000_8000, 1'b0, 0, 1'b0, 0);
        op(1, 32'h0000_1234, 32'h0000_4321, 1'b1, 0, 1'b0, 0);
        op(1, 32'h0000_0FFF, 32'h0000_0001, 1'b0, 0, 1'b0, 0);
        op(1, 32'h0000_A5A5, 32'h0000_5A5A, 1'b1, 5, 1'b0, 0);
        op(1, 32'h0000_3C3C, 32'h0000_0101, 1'b0, 0, 1'b1, 0);

        // Abort while the counter sits at 2, then confirm a clean restart.
        a_bus = 32'h0000_FFFF; b_bus = 32'h0000_FFFF; cin = 1'b1;
        in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_valid", {63'd0, out_valid[1]}, 64'd0);
        chk("abort_ready", {63'd0, in_ready[1]}, 64'd1);
        chk("abort_sum", {48'd0, sum16}, 64'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        op(1, 32'h0000_0002, 32'h0000_0003, 1'b0, 0, 1'b0, 0);

        prev_hold = 0;
        for (int i = 0; i < 100; i++) begin
            gap  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            hold = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            op(1, $urandom, $urandom, $urandom_range(1, 0) == 1, hold,
               $urandom_range(4, 0) == 0, (i == 0) ? 0 : 6 + gap + prev_hold);
            prev_hold = hold;
        end

        op(0, 32'h0000_000F, 32'h0000_0001, 1'b0, 0, 1'b0, 0);
        op(0, 32'h0000_0007, 32'h0000_0001, 1'b0, 0, 1'b0, 0);
        op(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 1'b0, 0);
        op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 2, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            op(0, $urandom, $urandom, $urandom_range(1, 0) == 1, 0, 1'b0, 0);
            op(2, $urandom, $urandom, $urandom_range(1, 0) == 1, 0, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
